// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue/writeback slice: datapath width,
// op-code constants and the issue FSM state encoding.
package alu_defs;

    localparam int DW = 32;

    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // True for op codes that are actually executed by the ALU.
    function automatic logic is_alu_op(input logic [2:0] fun);
        return (fun != OP_LDI) && (fun != OP_ILL);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake between an instruction source (master) and the
// issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_fun;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_ra;
    logic [AW-1:0] instr_rb;
    logic [DW-1:0] instr_imm;

    modport master (
        output instr_valid, instr_fun, instr_rd, instr_ra, instr_rb, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_fun, instr_rd, instr_ra, instr_rb, instr_imm,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// alu_regfile: NREG x DW register file, two async read ports, one sync
// write port, R0 hardwired to zero, async active-low clear.
// With DBG_READ_PORT_EN defined a third async read port is added.
module alu_regfile #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
`ifdef DBG_READ_PORT_EN
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
`endif
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);
    logic [DW-1:0] regs [NREG];

    // Storage; writes to R0 are dropped so it never leaves zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
`ifdef DBG_READ_PORT_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serial issue/writeback stage around the 32-bit ALU.
// One instruction every three cycles (IDLE -> EXEC -> WB).
// Optional macro DBG_READ_PORT_EN adds a combinational register read port.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | ready; latch instruction fields when instr_valid is high
//   ST_EXEC | drive ALU from the register file, capture result and flags
//   ST_WB   | write destination, pulse done/wb_valid, update status flags
module alu_issue_ctrl
    import alu_defs::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_issue_ctrl_if.slave instr,
    output logic [DW-1:0]   alu_operB,
    output logic [DW-1:0]   alu_operA,
    output logic [2:0]      alu_fun,
    input  logic [DW-1:0]   alu_result,
    input  logic            alu_carry,
    input  logic            alu_zero,
    input  logic            alu_negative,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_addr,
    output logic [DW-1:0]   wb_data,
    output logic            done,
    output logic            illegal_op,
`ifdef DBG_READ_PORT_EN
    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data,
`endif
    output logic            flag_carry,
    output logic            flag_zero,
    output logic            flag_negative
);
    state_t        state, state_n;
    logic [2:0]    fun_q;
    logic [AW-1:0] rd_q, ra_q, rb_q;
    logic [DW-1:0] imm_q, res_q;
    logic          c_q, z_q, n_q;
    logic [DW-1:0] ra_data, rb_data;

    alu_regfile #(.NREG(NREG), .AW(AW), .DW(DW)) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .ra_addr  (ra_q),
        .ra_data  (ra_data),
        .rb_addr  (rb_q),
        .rb_data  (rb_data),
`ifdef DBG_READ_PORT_EN
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
`endif
        .we       (wb_valid),
        .wa       (wb_addr),
        .wd       (wb_data)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Instruction latch, ALU capture and status flag update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fun_q <= '0; rd_q <= '0; ra_q <= '0; rb_q <= '0; imm_q <= '0;
            res_q <= '0; c_q <= 1'b0; z_q <= 1'b0; n_q <= 1'b0;
            flag_carry <= 1'b0; flag_zero <= 1'b0; flag_negative <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (instr.instr_valid) begin
                    fun_q <= instr.instr_fun;
                    rd_q  <= instr.instr_rd;
                    ra_q  <= instr.instr_ra;
                    rb_q  <= instr.instr_rb;
                    imm_q <= instr.instr_imm;
                end
                ST_EXEC: begin
                    res_q <= alu_result;
                    c_q   <= alu_carry;
                    z_q   <= alu_zero;
                    n_q   <= alu_negative;
                end
                ST_WB: begin
                    if (fun_q == OP_LDI) begin
                        flag_carry    <= 1'b0;
                        flag_zero     <= (imm_q == '0);
                        flag_negative <= 1'b0;
                    end else if (fun_q != OP_ILL) begin
                        flag_carry    <= c_q;
                        flag_zero     <= z_q;
                        flag_negative <= n_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and per-state outputs.
    always_comb begin
        state_n           = state;
        instr.instr_ready = 1'b0;
        alu_operB         = '0;
        alu_operA         = '0;
        alu_fun           = OP_LDI;
        wb_valid          = 1'b0;
        wb_addr           = rd_q;
        wb_data           = (fun_q == OP_LDI) ? imm_q : res_q;
        done              = 1'b0;
        illegal_op        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr.instr_ready = 1'b1;
                if (instr.instr_valid) state_n = ST_EXEC;
            end
            ST_EXEC: begin
                alu_operB = ra_data;
                alu_operA = rb_data;
                alu_fun   = is_alu_op(fun_q) ? fun_q : OP_LDI;
                state_n   = ST_WB;
            end
            ST_WB: begin
                done       = 1'b1;
                illegal_op = (fun_q == OP_ILL);
                wb_valid   = (fun_q != OP_ILL);
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule
